// File: rtl/arm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-RAM bus.
// STATUS at BASE_ADDR, TXDATA at BASE_ADDR+4, FIFO-buffered serializer.
module arm_uart_tx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_cen,
    input  logic        ram_wen,
    input  logic [3:0]  ram_flag,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_wdata,
    output logic [31:0] uart_rdata,
    output logic        uart_rsel,
    output logic        txd,
    output logic        tx_idle
);

    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CntBits   = PtrW + 1;
    localparam int unsigned BaudW     = $clog2(CLK_DIV);
    localparam int unsigned BaudLastI = CLK_DIV - 1;
    localparam logic [CntBits-1:0] Depth    = FIFO_DEPTH[CntBits-1:0];
    localparam logic [BaudW-1:0]   BaudLast = BaudLastI[BaudW-1:0];
    localparam logic [31:0]        DataAddr = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] count_q;
    logic               ovf_q;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               pop;

    logic status_hit, data_hit, data_wr, ovf_clr, rd_hit;
    logic full, busy, push, baud_end;
    logic [7:0]  count8;
    logic [31:0] status_word;
    logic        unused_bits;

    assign status_hit = ram_cen && (ram_addr == BASE_ADDR);
    assign data_hit   = ram_cen && (ram_addr == DataAddr);
    assign data_wr    = data_hit && ram_wen && ram_flag[0];
    assign ovf_clr    = status_hit && ram_wen && ram_flag[0] && ram_wdata[2];
    assign rd_hit     = (status_hit || data_hit) && !ram_wen;

    assign full     = (count_q == Depth);
    assign busy     = (count_q != '0) || (state_q != StIdle);
    // Room is judged on the pre-edge count; a same-cycle pop does not free a slot.
    assign push     = data_wr && !full;
    assign baud_end = (baud_q == BaudLast);

    assign count8      = 8'(count_q);
    assign status_word = {16'h0000, count8, 5'b00000, ovf_q, busy, full};
    assign tx_idle     = (count_q == '0) && (state_q == StIdle);
    assign unused_bits = ^{ram_flag[3:1], ram_wdata[31:8]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= ram_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntBits'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntBits'(1);
            end
            if (data_wr && full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Read port mirrors RAM latency: data and select valid one cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_rdata <= '0;
            uart_rsel  <= 1'b0;
        end else begin
            uart_rsel <= rd_hit;
            if (rd_hit) begin
                uart_rdata <= status_hit ? status_word : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd     = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                txd = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                txd = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
